// File: rtl/salu_pkg.sv
// Shared ssrc code map, FSM encoding and inline float constant tables for the
// scalar ALU operand-fetch stage.
package salu_pkg;

    localparam logic [7:0] SSRC_REG_MAX    = 8'h7F;
    localparam logic [7:0] SSRC_CONST_ZERO = 8'h80;
    localparam logic [7:0] SSRC_INT_POS_LO = 8'h81;
    localparam logic [7:0] SSRC_INT_POS_HI = 8'hC0;
    localparam logic [7:0] SSRC_INT_NEG_LO = 8'hC1;
    localparam logic [7:0] SSRC_INT_NEG_HI = 8'hD0;
    localparam logic [7:0] SSRC_FLT_LO     = 8'hF0;
    localparam logic [7:0] SSRC_FLT_HI     = 8'hF7;
    localparam logic [7:0] SSRC_VCCZ       = 8'hFB;
    localparam logic [7:0] SSRC_EXECZ      = 8'hFC;
    localparam logic [7:0] SSRC_SCC        = 8'hFD;
    localparam logic [7:0] SSRC_LIT        = 8'hFF;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_LIT     = 3'd3;
    localparam logic [2:0] ST_VALID   = 3'd4;

    // Order: 0.5, -0.5, 1.0, -1.0, 2.0, -2.0, 4.0, -4.0
    function automatic logic [31:0] flt32(input logic [2:0] idx);
        logic [31:0] r;
        case (idx)
            3'd0:    r = 32'h3F00_0000;
            3'd1:    r = 32'hBF00_0000;
            3'd2:    r = 32'h3F80_0000;
            3'd3:    r = 32'hBF80_0000;
            3'd4:    r = 32'h4000_0000;
            3'd5:    r = 32'hC000_0000;
            3'd6:    r = 32'h4080_0000;
            default: r = 32'hC080_0000;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] flt64(input logic [2:0] idx);
        logic [15:0] hi;
        case (idx)
            3'd0:    hi = 16'h3FE0;
            3'd1:    hi = 16'hBFE0;
            3'd2:    hi = 16'h3FF0;
            3'd3:    hi = 16'hBFF0;
            3'd4:    hi = 16'h4000;
            3'd5:    hi = 16'hC000;
            3'd6:    hi = 16'h4010;
            default: hi = 16'hC010;
        endcase
        return {hi, 48'h0};
    endfunction

endpackage

// File: rtl/salu_const_decode.sv
// Resolves one ssrc code to a 64-bit operand: register data, inline integer or
// float constant, or the instruction literal; flags reserved codes.
module salu_const_decode
    import salu_pkg::*;
#(
    parameter logic [7:0] LIT_CODE = SSRC_LIT,
    parameter logic [7:0] REG_MAX  = SSRC_REG_MAX
) (
    input  logic [7:0]  code,
    input  logic        is64,
    input  logic [63:0] rf_data,
    input  logic [31:0] lit,
    output logic [63:0] value,
    output logic        is_lit,
    output logic        err
);

    logic [7:0]  mag;
    logic [31:0] neg32;

    always_comb begin
        value  = '0;
        is_lit = 1'b0;
        err    = 1'b0;
        mag    = code - SSRC_CONST_ZERO;
        neg32  = 32'd0 - {24'h0, code - SSRC_INT_POS_HI};
        if (code <= REG_MAX || code == SSRC_VCCZ || code == SSRC_EXECZ || code == SSRC_SCC) begin
            value = is64 ? rf_data : {32'h0, rf_data[31:0]};
        end else if (code == LIT_CODE) begin
            is_lit = 1'b1;
            value  = is64 ? {{32{lit[31]}}, lit} : {32'h0, lit};
        end else if (code == SSRC_CONST_ZERO) begin
            value = '0;
        end else if (code >= SSRC_INT_POS_LO && code <= SSRC_INT_POS_HI) begin
            value = {56'h0, mag};
        end else if (code >= SSRC_INT_NEG_LO && code <= SSRC_INT_NEG_HI) begin
            value = is64 ? {{32{neg32[31]}}, neg32} : {32'h0, neg32};
        end else if (code >= SSRC_FLT_LO && code <= SSRC_FLT_HI) begin
            value = is64 ? flt64(code[2:0]) : {32'h0, flt32(code[2:0])};
        end else begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/salu_operand_fetch.sv
// SALU operand-fetch stage: issues register-file reads, resolves constants and
// the instruction literal, and hands a 64-bit operand pair to execute.
module salu_operand_fetch
    import salu_pkg::*;
#(
    parameter logic [7:0] LIT_CODE = SSRC_LIT,
    parameter logic [7:0] REG_MAX  = SSRC_REG_MAX
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_ssrc0,
    input  logic [7:0]  in_ssrc1,
    input  logic [7:0]  in_sdst,
    input  logic [7:0]  in_opcode,
    input  logic        in_is64,
    input  logic        lit_valid,
    output logic        lit_ready,
    input  logic [31:0] lit_data,
    output logic [7:0]  rf_s0,
    output logic [7:0]  rf_s1,
    input  logic [63:0] rf_r0,
    input  logic [63:0] rf_r1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_op0,
    output logic [63:0] out_op1,
    output logic [7:0]  out_sdst,
    output logic [7:0]  out_opcode,
    output logic        out_is64,
    output logic        out_err
);

    logic [2:0]  state_q, state_d;
    logic [7:0]  ssrc0_q, ssrc0_d, ssrc1_q, ssrc1_d;
    logic [7:0]  sdst_q, sdst_d, opcode_q, opcode_d;
    logic        is64_q, is64_d;
    logic [7:0]  rf_s0_q, rf_s0_d, rf_s1_q, rf_s1_d;
    logic [63:0] op0_q, op0_d, op1_q, op1_d;
    logic        lit0_q, lit0_d, lit1_q, lit1_d;
    logic        err_q, err_d;

    logic [63:0] val0, val1;
    logic        islit0, islit1, err0, err1;

    // Literal-sourced values depend only on code/width/literal, so the same
    // decoders are reused in LIT once the literal dword arrives.
    salu_const_decode #(.LIT_CODE(LIT_CODE), .REG_MAX(REG_MAX)) u_dec0 (
        .code    (ssrc0_q),
        .is64    (is64_q),
        .rf_data (rf_r0),
        .lit     (lit_data),
        .value   (val0),
        .is_lit  (islit0),
        .err     (err0)
    );

    salu_const_decode #(.LIT_CODE(LIT_CODE), .REG_MAX(REG_MAX)) u_dec1 (
        .code    (ssrc1_q),
        .is64    (is64_q),
        .rf_data (rf_r1),
        .lit     (lit_data),
        .value   (val1),
        .is_lit  (islit1),
        .err     (err1)
    );

    always_comb begin
        state_d  = state_q;
        ssrc0_d  = ssrc0_q;
        ssrc1_d  = ssrc1_q;
        sdst_d   = sdst_q;
        opcode_d = opcode_q;
        is64_d   = is64_q;
        rf_s0_d  = rf_s0_q;
        rf_s1_d  = rf_s1_q;
        op0_d    = op0_q;
        op1_d    = op1_q;
        lit0_d   = lit0_q;
        lit1_d   = lit1_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ssrc0_d  = in_ssrc0;
                    ssrc1_d  = in_ssrc1;
                    sdst_d   = in_sdst;
                    opcode_d = in_opcode;
                    is64_d   = in_is64;
                    err_d    = 1'b0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rf_s0_d = ssrc0_q;
                rf_s1_d = ssrc1_q;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                op0_d   = val0;
                op1_d   = val1;
                lit0_d  = islit0;
                lit1_d  = islit1;
                err_d   = err0 | err1;
                state_d = (islit0 || islit1) ? ST_LIT : ST_VALID;
            end
            ST_LIT: begin
                if (lit_valid) begin
                    if (lit0_q) op0_d = val0;
                    if (lit1_q) op1_d = val1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ssrc0_q  <= '0;
            ssrc1_q  <= '0;
            sdst_q   <= '0;
            opcode_q <= '0;
            is64_q   <= 1'b0;
            rf_s0_q  <= '0;
            rf_s1_q  <= '0;
            op0_q    <= '0;
            op1_q    <= '0;
            lit0_q   <= 1'b0;
            lit1_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ssrc0_q  <= ssrc0_d;
            ssrc1_q  <= ssrc1_d;
            sdst_q   <= sdst_d;
            opcode_q <= opcode_d;
            is64_q   <= is64_d;
            rf_s0_q  <= rf_s0_d;
            rf_s1_q  <= rf_s1_d;
            op0_q    <= op0_d;
            op1_q    <= op1_d;
            lit0_q   <= lit0_d;
            lit1_q   <= lit1_d;
            err_q    <= err_d;
        end
    end

    // Addresses are driven straight from the latched codes during ISSUE so the
    // register file sees them a cycle early; the registered copy holds them after.
    assign rf_s0      = (state_q == ST_ISSUE) ? ssrc0_q : rf_s0_q;
    assign rf_s1      = (state_q == ST_ISSUE) ? ssrc1_q : rf_s1_q;
    assign in_ready   = (state_q == ST_IDLE);
    assign lit_ready  = (state_q == ST_LIT);
    assign out_valid  = (state_q == ST_VALID);
    assign out_op0    = op0_q;
    assign out_op1    = op1_q;
    assign out_sdst   = sdst_q;
    assign out_opcode = opcode_q;
    assign out_is64   = is64_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_salu_operand_fetch.sv
// Directed bench for salu_operand_fetch with a registered register-file model.
module tb_salu_operand_fetch;

    logic        clock, reset;
    logic        in_valid, in_ready;
    logic [7:0]  in_ssrc0, in_ssrc1, in_sdst, in_opcode;
    logic        in_is64;
    logic        lit_valid, lit_ready;
    logic [31:0] lit_data;
    logic [7:0]  rf_s0, rf_s1;
    logic [63:0] rf_r0, rf_r1;
    logic        out_valid, out_ready;
    logic [63:0] out_op0, out_op1;
    logic [7:0]  out_sdst, out_opcode;
    logic        out_is64, out_err;

    int errors = 0;
    int checks = 0;
    int lit_hs = 0;
    int hs_base;

    logic [63:0] rf_mem [256];

    salu_operand_fetch #(.LIT_CODE(8'hFF), .REG_MAX(8'h7F)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ssrc0(in_ssrc0), .in_ssrc1(in_ssrc1), .in_sdst(in_sdst),
        .in_opcode(in_opcode), .in_is64(in_is64),
        .lit_valid(lit_valid), .lit_ready(lit_ready), .lit_data(lit_data),
        .rf_s0(rf_s0), .rf_s1(rf_s1), .rf_r0(rf_r0), .rf_r1(rf_r1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op0(out_op0), .out_op1(out_op1), .out_sdst(out_sdst),
        .out_opcode(out_opcode), .out_is64(out_is64), .out_err(out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        rf_r0 <= rf_mem[rf_s0];
        rf_r1 <= rf_mem[rf_s1];
        if (lit_valid && lit_ready) lit_hs <= lit_hs + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction for one edge; returns in ISSUE.
    task automatic issue(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] dst,
                         input logic [7:0] opc, input logic w);
        in_ssrc0 = s0; in_ssrc1 = s1; in_sdst = dst; in_opcode = opc; in_is64 = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (lit_ready !== 1'b0) begin errors++; $display("FAIL rst_lit_ready got=%b exp=0", lit_ready); end
        checks++; if ({rf_s0, rf_s1} !== 16'h0) begin errors++; $display("FAIL rst_rf_s got=%h exp=0000", {rf_s0, rf_s1}); end
        checks++; if ({out_op0, out_op1} !== 128'h0) begin errors++; $display("FAIL rst_ops got=%h %h exp=0", out_op0, out_op1); end
        checks++; if ({out_sdst, out_opcode, out_is64, out_err} !== 18'h0) begin errors++; $display("FAIL rst_misc got=%h exp=0", {out_sdst, out_opcode, out_is64, out_err}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        issue(8'h05, 8'h81, 8'h21, 8'h0A, 1'b0);
        checks++; if (rf_s0 !== 8'h05) begin errors++; $display("FAIL basic_rf_s0 got=%h exp=05", rf_s0); end
        checks++; if (rf_s1 !== 8'h81) begin errors++; $display("FAIL basic_rf_s1 got=%h exp=81", rf_s1); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_issue got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_capture got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_lat3 got=%b exp=1", out_valid); end
        checks++; if (out_op0 !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL basic_op0 got=%h exp=%h", out_op0, 64'h0000_0000_1234_5678); end
        checks++; if (out_op1 !== 64'h1) begin errors++; $display("FAIL basic_op1 got=%h exp=1", out_op1); end
        checks++; if ({out_sdst, out_opcode, out_is64, out_err} !== {8'h21, 8'h0A, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_pass got=%h %h %b %b exp=21 0a 0 0", out_sdst, out_opcode, out_is64, out_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready got=%b exp=0", in_ready); end
        retire();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL basic_idle got=%b exp=10", {in_ready, out_valid}); end
        checks++; if (rf_s0 !== 8'h05) begin errors++; $display("FAIL basic_rf_hold got=%h exp=05", rf_s0); end
    endtask

    task automatic test_const();
        issue(8'hC1, 8'hF2, 8'h01, 8'h02, 1'b1);
        step(); step();
        checks++; if (out_op0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL const_neg64 got=%h exp=ffffffffffffffff", out_op0); end
        checks++; if (out_op1 !== 64'h3FF0_0000_0000_0000) begin errors++; $display("FAIL const_f64_1p0 got=%h exp=3ff0000000000000", out_op1); end
        retire();
        issue(8'hF7, 8'hC0, 8'h01, 8'h02, 1'b1);
        step(); step();
        checks++; if (out_op0 !== 64'hC010_0000_0000_0000) begin errors++; $display("FAIL const_f64_m4 got=%h exp=c010000000000000", out_op0); end
        checks++; if (out_op1 !== 64'h40) begin errors++; $display("FAIL const_pos64 got=%h exp=40", out_op1); end
        retire();
        issue(8'hC1, 8'hF7, 8'h01, 8'h02, 1'b0);
        step(); step();
        checks++; if (out_op0 !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL const_neg32 got=%h exp=00000000ffffffff", out_op0); end
        checks++; if (out_op1 !== 64'h0000_0000_C080_0000) begin errors++; $display("FAIL const_f32_m4 got=%h exp=00000000c0800000", out_op1); end
        retire();
    endtask

    task automatic test_literal();
        hs_base = lit_hs;
        lit_valid = 1'b0;
        lit_data = 32'h8000_0001;
        issue(8'hFF, 8'hFF, 8'h10, 8'h20, 1'b1);
        step(); step();
        for (int i = 0; i < 3; i++) begin
            checks++; if ({lit_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL lit_wait%0d got=%b exp=10", i, {lit_ready, out_valid}); end
            if (i < 2) step();
        end
        lit_valid = 1'b1;
        step();
        lit_valid = 1'b0;
        checks++; if ({lit_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL lit_done got=%b exp=01", {lit_ready, out_valid}); end
        checks++; if (out_op0 !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL lit_op0 got=%h exp=ffffffff80000001", out_op0); end
        checks++; if (out_op1 !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL lit_op1 got=%h exp=ffffffff80000001", out_op1); end
        retire();
        checks++; if (lit_hs - hs_base !== 1) begin errors++; $display("FAIL lit_handshakes got=%0d exp=1", lit_hs - hs_base); end
    endtask

    task automatic test_err();
        issue(8'hD5, 8'h81, 8'h00, 8'h00, 1'b0);
        step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL err_valid got=%b exp=1", out_valid); end
        checks++; if (out_op0 !== 64'h0) begin errors++; $display("FAIL err_op0 got=%h exp=0", out_op0); end
        checks++; if (out_op1 !== 64'h1) begin errors++; $display("FAIL err_op1 got=%h exp=1", out_op1); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL err_flag got=%b exp=1", out_err); end
        retire();
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL err_hold_idle got=%b exp=1", out_err); end
        issue(8'h80, 8'h10, 8'h00, 8'h00, 1'b1);
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL err_clear_accept got=%b exp=0", out_err); end
        step(); step();
        checks++; if (out_op0 !== 64'h0) begin errors++; $display("FAIL err_zero_op0 got=%h exp=0", out_op0); end
        checks++; if (out_op1 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL err_reg64_op1 got=%h exp=0123456789abcdef", out_op1); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL err_legal got=%b exp=0", out_err); end
        retire();
    endtask

    task automatic test_backpressure();
        issue(8'hFB, 8'hC5, 8'h33, 8'h44, 1'b0);
        step(); step();
        in_ssrc0 = 8'h81; in_ssrc1 = 8'h82; in_sdst = 8'h55; in_opcode = 8'h66; in_is64 = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL bp_hs%0d got=%b exp=10", i, {out_valid, in_ready}); end
            checks++; if (out_op0 !== 64'h0000_0000_3333_4444 || out_op1 !== 64'h0000_0000_FFFF_FFFB) begin errors++; $display("FAIL bp_ops%0d got=%h %h exp=0000000033334444 00000000fffffffb", i, out_op0, out_op1); end
            checks++; if ({out_sdst, out_opcode, out_is64} !== {8'h33, 8'h44, 1'b0}) begin errors++; $display("FAIL bp_pass%0d got=%h %h %b exp=33 44 0", i, out_sdst, out_opcode, out_is64); end
            step();
        end
        in_valid = 1'b0;
        retire();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got=%b exp=1", in_ready); end
        step(); step(); step();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_no_ghost got=%b exp=01", {out_valid, in_ready}); end
        checks++; if (rf_s0 !== 8'hFB) begin errors++; $display("FAIL bp_rf_s0 got=%h exp=fb", rf_s0); end
    endtask

    task automatic test_reset_mid();
        hs_base = lit_hs;
        issue(8'hFF, 8'h05, 8'h00, 8'h00, 1'b0);
        step(); step();
        checks++; if (lit_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_lit got=%b exp=1", lit_ready); end
        lit_data = 32'h1234_0000;
        lit_valid = 1'b1;
        reset = 1'b1;
        #2;
        checks++; if ({out_valid, lit_ready, in_ready} !== 3'b001) begin errors++; $display("FAIL rmid_async got=%b exp=001", {out_valid, lit_ready, in_ready}); end
        checks++; if ({out_op0, rf_s0} !== 72'h0) begin errors++; $display("FAIL rmid_clear got=%h %h exp=0", out_op0, rf_s0); end
        step();
        reset = 1'b0;
        lit_valid = 1'b0;
        step();
        checks++; if (lit_hs !== hs_base) begin errors++; $display("FAIL rmid_lit_consumed got=%0d exp=%0d", lit_hs, hs_base); end
        issue(8'h82, 8'hF0, 8'h07, 8'h08, 1'b0);
        step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_after_valid got=%b exp=1", out_valid); end
        checks++; if (out_op0 !== 64'h2 || out_op1 !== 64'h0000_0000_3F00_0000) begin errors++; $display("FAIL rmid_after_ops got=%h %h exp=2 000000003f000000", out_op0, out_op1); end
        retire();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rf_mem[i] = 64'hCAFE_F00D_0000_0000 + 64'(i);
        rf_mem[8'h05] = 64'hDEAD_BEEF_1234_5678;
        rf_mem[8'h10] = 64'h0123_4567_89AB_CDEF;
        rf_mem[8'hFB] = 64'h1111_2222_3333_4444;
        reset = 1'b0; in_valid = 1'b0; in_ssrc0 = '0; in_ssrc1 = '0; in_sdst = '0;
        in_opcode = '0; in_is64 = 1'b0; lit_valid = 1'b0; lit_data = '0; out_ready = 1'b0;
        #3;
        test_reset();
        test_basic();
        test_const();
        test_literal();
        test_err();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
